// File: rtl/icache_refill_ctrl.sv
// ICache line refill: one 4-beat INCR AXI4 read burst per miss, beats forwarded to the return buffer.
// Optional macro ICACHE_REFILL_RRESP_CHECK_EN enables the sticky refill_err flag.
module icache_refill_ctrl #(
    parameter int          ADDR_W   = 32,
    parameter logic [3:0]  ARID_VAL = 4'd0,
    parameter int          BEATS    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic [3:0]        arid,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    output logic              buf_rvalid,
    output logic              buf_rlast,
    output logic [31:0]       buf_rdata,
    output logic              refill_done,
    output logic              refill_err
);

    typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_t;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [1:0]          r_cnt;
    logic                w_accept;
    logic                w_beat;
    logic                w_last_beat;
    logic                w_unused_lo;

    assign w_unused_lo = ^req_addr[3:0];

    assign arlen   = 8'(BEATS - 1);
    assign arsize  = 3'b010;
    assign arburst = 2'b01;
    assign arid    = ARID_VAL;
    assign araddr  = r_addr;

    assign w_accept    = (r_state == S_IDLE) && req_valid;
    assign w_beat      = (r_state == S_R) && rvalid;
    // Completion is decided by beat count alone; rlast only feeds the error check.
    assign w_last_beat = w_beat && (r_cnt == 2'(BEATS - 1));

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        arvalid     = 1'b0;
        rready      = 1'b0;
        buf_rvalid  = 1'b0;
        buf_rlast   = 1'b0;
        buf_rdata   = rdata;
        refill_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_state_nxt = S_AR;
            end
            S_AR: begin
                arvalid = 1'b1;
                if (arready) w_state_nxt = S_R;
            end
            S_R: begin
                rready     = 1'b1;
                buf_rvalid = w_beat;
                buf_rlast  = w_last_beat;
                if (w_last_beat) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                refill_done = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_addr <= {req_addr[ADDR_W-1:4], 4'b0000};
                r_cnt  <= 2'd0;
            end else if (w_beat) begin
                r_cnt  <= r_cnt + 2'd1;
            end
        end
    end

`ifdef ICACHE_REFILL_RRESP_CHECK_EN
    logic r_err;
    logic w_beat_err;

    assign w_beat_err = w_beat && ((rresp != 2'b00) || (rlast != (r_cnt == 2'(BEATS - 1))));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             r_err <= 1'b0;
        else if (w_accept)   r_err <= 1'b0;
        else if (w_beat_err) r_err <= 1'b1;
    end

    assign refill_err = r_err;
`else
    logic w_unused_resp;
    assign w_unused_resp = ^{rresp, rlast};
    assign refill_err    = 1'b0;
`endif

endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
AXI4 read-master refill controller for the instruction cache, directly upstream of the cache return buffer.
- Accepts one line-miss request from the ICache miss FSM.
- Issues a single 4-beat, 32-bit INCR burst on AR.
- Accepts the R beats and forwards each one, zero-latency, to the return buffer as valid/last/data.
- Pulses completion to the miss FSM once the line is assembled.

Parameters:
ADDR_W, 32, request and AR address width
ARID_VAL, 4'd0, constant ID driven on arid
BEATS, 4, beats per line; fixed at 4, arlen = BEATS-1

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
req_valid  input  1  miss FSM requests a line refill
req_ready  output  1  controller can accept a request
req_addr  input  ADDR_W  miss address; bits [3:0] ignored
araddr  output  ADDR_W  AXI read address, line-aligned
arlen  output  8  constant 8'd3
arsize  output  3  constant 3'b010
arburst  output  2  constant 2'b01 (INCR)
arid  output  4  constant ARID_VAL
arvalid  output  1  AR valid
arready  input  1  AR ready
rdata  input  32  AXI read data
rresp  input  2  AXI read response
rlast  input  1  AXI last beat
rvalid  input  1  AXI read valid
rready  output  1  AXI read ready
buf_rvalid  output  1  beat valid to return buffer
buf_rlast  output  1  final beat of line to return buffer
buf_rdata  output  32  beat data to return buffer
refill_done  output  1  one-cycle pulse: line complete in return buffer
refill_err  output  1  sticky error flag (see Optional Feature)

Behaviour:
- FSM states: IDLE, AR, R, DONE. Async reset sends the FSM to IDLE, clears the beat counter and clears the address register.
- Reset values: req_ready=1 (IDLE), arvalid=0, rready=0, buf_rvalid=0, buf_rlast=0, refill_done=0, refill_err=0, araddr=0.
- IDLE:
  - req_ready=1.
  - On req_valid: latch {req_addr[ADDR_W-1:4],4'b0} into the address register, clear the beat counter, go to AR.
- AR:
  - arvalid=1; araddr is driven from the register and is held stable until the handshake.
  - On arvalid&&arready, go to R. arvalid deasserts the following cycle.
  - req_ready=0 in every state except IDLE.
- R:
  - rready=1.
  - Each rvalid&&rready is a beat: buf_rvalid=1 in the same cycle, buf_rdata=rdata (combinational pass-through). The return buffer registers the data.
  - The 2-bit beat counter increments per beat.
  - buf_rlast=1 on the beat where counter==3.
  - After that beat, go to DONE.
  - Gaps (rvalid=0) are tolerated indefinitely; the counter holds.
- Completion rule: completion is by beat count, not by rlast.
  - rlast arriving at counter!=3 is a protocol error: the beat is still forwarded, and refill_err is set when the feature is enabled.
  - rlast missing at counter==3 is also an error, handled the same way.
- DONE:
  - refill_done=1 for exactly one cycle; no other outputs are active.
  - Return to IDLE. The next request can be accepted in the cycle after DONE.
  - Minimum request-to-done latency: 1 (AR) + 4 (R, no gaps) + 1 (DONE) = 6 cycles after acceptance.
- Outside R, buf_rvalid=0 regardless of rvalid, and rready=0.
- Only one outstanding burst at a time. req_valid outside IDLE is ignored; the request is not queued.
- Reset mid-burst aborts immediately: arvalid and rready drop. This AXI violation is permitted only at system reset.

Optional Feature:
Macro: ICACHE_REFILL_RRESP_CHECK_EN.
- Enabled:
  - refill_err is set on any beat with rresp!=2'b00.
  - It is also set on the rlast/count mismatch.
  - It stays set until the next request is accepted in IDLE, where it is cleared.
  - The line is still completed and refill_done still pulses.
- Disabled: refill_err is tied to 0 and rresp is unused.

Test Plan:
1. Request 0x1C00_0048, arready asserted 2 cycles late -> araddr=0x1C00_0040 stable for 3 cycles, arlen=3; 4 back-to-back beats A0..A3 -> buf_rvalid for 4 cycles, buf_rlast on A3, refill_done 1 cycle later, total 8 cycles.
2. Beats with 1-cycle rvalid gaps between each -> buf_rvalid only on handshake cycles; counter holds during gaps; buf_rlast on 4th beat only.
3. Back-to-back requests 0x100 then 0x200 held on req_valid -> second accepted the cycle after refill_done; second araddr=0x200; req_valid during first burst ignored.
4. Assert rst after beat 2 -> arvalid=0, rready=0, req_ready=1 in the same cycle; new request restarts the counter from 0.
5. With ICACHE_REFILL_RRESP_CHECK_EN, rresp=2'b10 on beat 1 -> refill_err=1 through done; cleared on next accepted request. Without the macro -> refill_err stays 0.
6. rlast on beat 2 (early) -> 4 beats still consumed, buf_rlast only on beat 4, refill_err=1 when the macro is enabled.
